// File: rtl/cmd_packet_assembler.sv
// Collects PACK_NUM received UART bytes into one packet and holds it until the
// downstream serializer accepts it. The last byte is a control byte decoded onto flag outputs.
module cmd_packet_assembler #(
    parameter int DATA_BIT     = 8,
    parameter int PACK_NUM     = 3,
    parameter int TIMEOUT_CLKS = 52100
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_BIT-1:0]                i_data,
    input  logic                               i_rx_done_tick,
    input  logic                               i_ready,
    output logic [PACK_NUM*DATA_BIT-1:0]       o_packet,
    output logic                               o_valid,
    output logic                               o_start,
    output logic                               o_stop,
    output logic                               o_mode,
    output logic [3:0]                         o_channel,
    output logic [$clog2(PACK_NUM+1)-1:0]      o_byte_cnt,
    output logic                               o_timeout_tick,
    output logic                               o_overrun_tick,
    output logic [1:0]                         o_state
);

    localparam int CW = $clog2(PACK_NUM + 1);
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int CB = (PACK_NUM - 1) * DATA_BIT;
    localparam logic [CW-1:0] LAST_BYTE = CW'(PACK_NUM - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    // Handshake: a packet transfers on any rising edge where o_valid and i_ready are both 1.
    logic [1:0]    state;
    logic [TW-1:0] to_cnt;

    assign o_state   = state;
    assign o_valid   = (state == S_HOLD);
    assign o_start   = o_valid & o_packet[CB + 0];
    assign o_stop    = o_valid & o_packet[CB + 1];
    assign o_mode    = o_valid & o_packet[CB + 2];
    assign o_channel = o_valid ? o_packet[CB + 3 +: 4] : 4'd0;

    // rst_n is an active-high asynchronous reset in this codebase despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state          <= S_IDLE;
            to_cnt         <= '0;
            o_packet       <= '0;
            o_byte_cnt     <= '0;
            o_timeout_tick <= 1'b0;
            o_overrun_tick <= 1'b0;
        end else begin
            o_timeout_tick <= 1'b0;
            o_overrun_tick <= 1'b0;
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (i_rx_done_tick) begin
                        o_packet[0 +: DATA_BIT] <= i_data;
                        o_byte_cnt              <= CW'(1);
                        state                   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // A strobe on the expiry cycle takes priority over the timeout.
                    if (i_rx_done_tick) begin
                        o_packet[o_byte_cnt*DATA_BIT +: DATA_BIT] <= i_data;
                        o_byte_cnt <= o_byte_cnt + 1'b1;
                        to_cnt     <= '0;
                        if (o_byte_cnt == LAST_BYTE) begin
                            state <= S_HOLD;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state          <= S_IDLE;
                        o_packet       <= '0;
                        o_byte_cnt     <= '0;
                        to_cnt         <= '0;
                        o_timeout_tick <= 1'b1;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    to_cnt <= '0;
                    if (i_ready) begin
                        // Release and, if a byte arrives now, start the next packet with it.
                        if (i_rx_done_tick) begin
                            o_packet[0 +: DATA_BIT] <= i_data;
                            o_byte_cnt              <= CW'(1);
                            state                   <= S_COLLECT;
                        end else begin
                            o_byte_cnt <= '0;
                            state      <= S_IDLE;
                        end
                    end else if (i_rx_done_tick) begin
                        o_overrun_tick <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    to_cnt     <= '0;
                    o_byte_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_packet_assembler.sv
// Directed bench for cmd_packet_assembler: the driver queues expected packets and
// tick events, and a negedge monitor checks them as the DUT presents them.
module tb_cmd_packet_assembler;

    localparam int DB = 8;
    localparam int PN = 3;
    localparam int TO = 20;
    localparam int PW = PN * DB;
    localparam int CW = $clog2(PN + 1);
    localparam int EW = PW + 7;

    logic          clk;
    logic          rst_n;
    logic [DB-1:0] i_data;
    logic          i_rx_done_tick;
    logic          i_ready;
    logic [PW-1:0] o_packet;
    logic          o_valid;
    logic          o_start;
    logic          o_stop;
    logic          o_mode;
    logic [3:0]    o_channel;
    logic [CW-1:0] o_byte_cnt;
    logic          o_timeout_tick;
    logic          o_overrun_tick;
    logic [1:0]    o_state;

    cmd_packet_assembler #(
        .DATA_BIT    (DB),
        .PACK_NUM    (PN),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_data        (i_data),
        .i_rx_done_tick(i_rx_done_tick),
        .i_ready       (i_ready),
        .o_packet      (o_packet),
        .o_valid       (o_valid),
        .o_start       (o_start),
        .o_stop        (o_stop),
        .o_mode        (o_mode),
        .o_channel     (o_channel),
        .o_byte_cnt    (o_byte_cnt),
        .o_timeout_tick(o_timeout_tick),
        .o_overrun_tick(o_overrun_tick),
        .o_state       (o_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [1:0]    tick_q[$];   // 2'b01 timeout, 2'b10 overrun

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input logic [PW-1:0] pkt, input logic [3:0] ch,
                            input logic mode, input logic stop, input logic start);
        exp_q.push_back({ch, mode, stop, start, pkt});
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {o_packet, o_valid, o_start, o_stop, o_mode, o_channel, o_byte_cnt,
                   o_timeout_tick, o_overrun_tick, o_state}, 64'd0);
    endtask

    // ---------------- monitor ----------------
    logic          held;
    logic [PW-1:0] held_pkt;
    logic [EW-1:0] e_item;
    logic [1:0]    t_item;

    always @(negedge clk) begin
        if (rst_n) begin
            held = 1'b0;
        end else begin
            if (o_valid) begin
                if (held) chk("hold_stable", o_packet, held_pkt);
                else begin
                    held     = 1'b1;
                    held_pkt = o_packet;
                end
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_packet: got %0h expected none", o_packet);
                    end else begin
                        e_item = exp_q.pop_front();
                        chk("packet", {o_channel, o_mode, o_stop, o_start, o_packet}, e_item);
                    end
                    held = 1'b0;
                end
            end else begin
                held = 1'b0;
            end
            if (o_timeout_tick || o_overrun_tick) begin
                if (tick_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_tick: got %0b expected none", {o_overrun_tick, o_timeout_tick});
                end else begin
                    t_item = tick_q.pop_front();
                    chk("tick_kind", {o_overrun_tick, o_timeout_tick}, t_item);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [DB-1:0] b);
        i_data         = b;
        i_rx_done_tick = 1'b1;
        step(1);
        i_rx_done_tick = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b1;
        i_data         = '0;
        i_rx_done_tick = 1'b0;
        i_ready        = 1'b0;
        step(3);
        chk_reset_outputs("reset_state");
        rst_n = 1'b0;
        step(2);

        // Basic packet with immediate acceptance.
        i_ready = 1'b1;
        push_pkt(24'h015555, 4'd0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h55);
        chk("cnt_after_b0", o_byte_cnt, 1);
        send_byte(8'h55);
        chk("cnt_after_b1", o_byte_cnt, 2);
        send_byte(8'h01);
        chk("valid_latency", o_valid, 1);
        chk("pkt_015555", o_packet, 24'h015555);
        chk("start_bit", o_start, 1);
        step(1);
        chk("valid_one_cycle", o_valid, 0);
        chk("cnt_after_release", o_byte_cnt, 0);

        // Held packet under backpressure, then an overrun byte.
        i_ready = 1'b0;
        push_pkt(24'h1F5555, 4'd3, 1'b1, 1'b1, 1'b1);
        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(8'h1F);
        step(99);
        chk("valid_held_100", o_valid, 1);
        tick_q.push_back(2'b10);
        send_byte(8'hAA);
        chk("overrun_pulse", o_overrun_tick, 1);
        chk("pkt_after_overrun", o_packet, 24'h1F5555);
        step(1);
        chk("overrun_one_cycle", o_overrun_tick, 0);
        i_ready = 1'b1;
        step(1);
        i_ready = 1'b0;
        chk("released_after_ready", o_valid, 0);

        // Timeout after a single byte, exact expiry cycle.
        tick_q.push_back(2'b01);
        send_byte(8'h55);
        step(TO - 1);
        chk("no_timeout_early", {o_timeout_tick, o_byte_cnt}, {1'b0, 2'd1});
        step(1);
        chk("timeout_pulse", o_timeout_tick, 1);
        chk("cnt_after_timeout", o_byte_cnt, 0);
        chk("idle_after_timeout", o_state, 0);
        step(2);
        i_ready = 1'b1;
        push_pkt(24'h3B2211, 4'd7, 1'b0, 1'b1, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h3B);
        chk("channel_7", o_channel, 7);
        step(2);

        // Strobe landing exactly on the expiry cycle wins.
        push_pkt(24'h076655, 4'd0, 1'b1, 1'b1, 1'b1);
        send_byte(8'h55);
        step(TO - 1);
        send_byte(8'h66);
        chk("strobe_at_expiry_cnt", o_byte_cnt, 2);
        chk("strobe_at_expiry_tick", o_timeout_tick, 0);
        step(3);
        chk("no_late_timeout", o_state, 1);
        send_byte(8'h07);
        step(2);

        // Release and new byte 0 in the same cycle.
        i_ready = 1'b0;
        push_pkt(24'h030201, 4'd0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        step(3);
        i_ready = 1'b1;
        send_byte(8'h77);
        chk("ready_and_strobe_valid", o_valid, 0);
        chk("ready_and_strobe_cnt", o_byte_cnt, 1);
        push_pkt(24'h098877, 4'd1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h88);
        send_byte(8'h09);
        chk("byte0_is_77", o_packet[7:0], 8'h77);
        step(2);

        // Reset mid-packet.
        send_byte(8'h01);
        send_byte(8'h02);
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("reset_mid_packet");
        step(2);
        rst_n = 1'b0;
        step(1);
        push_pkt(24'h030201, 4'd0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        chk("pkt_after_reset", o_packet, 24'h030201);
        step(2);

        // Reset while holding: held data is dropped with no pulse.
        i_ready = 1'b0;
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        step(2);
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("reset_in_hold");
        step(2);
        rst_n = 1'b0;
        step(5);
        chk("idle_after_hold_reset", {o_valid, o_byte_cnt}, 0);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("tick_q_drained", tick_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_packet_assembler.md
CMD_PACKET_ASSEMBLER -- requirements
Module: cmd_packet_assembler

Interface
REQ-001 SHALL have parameter DATA_BIT, default 8, byte width from the UART receiver.
REQ-002 SHALL have parameter PACK_NUM, default 3, bytes per packet; legal range 2..16.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 52100, idle clocks allowed between bytes of one packet.
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_data  input  DATA_BIT  received UART byte.
REQ-007 SHALL have port i_rx_done_tick  input  1  one-cycle strobe; i_data is valid in that cycle.
REQ-008 SHALL have port i_ready  input  1  downstream serializer can accept a packet.
REQ-009 SHALL have port o_packet  output  PACK_NUM*DATA_BIT  assembled packet.
REQ-010 SHALL have port o_valid  output  1  o_packet holds a complete packet.
REQ-011 SHALL have port o_start, o_stop, o_mode  output  1 each  decoded control-byte bits 0, 1, 2.
REQ-012 SHALL have port o_channel  output  4  decoded control-byte bits 6:3.
REQ-013 SHALL have port o_byte_cnt  output  clog2(PACK_NUM+1)  bytes collected in the current packet.
REQ-014 SHALL have port o_timeout_tick  output  1  one-cycle pulse when a partial packet is discarded.
REQ-015 SHALL have port o_overrun_tick  output  1  one-cycle pulse when an incoming byte is dropped.

Function
REQ-016 SHALL implement states IDLE, COLLECT and HOLD.
REQ-017 Byte k of a packet (k = 0 first) SHALL be stored at o_packet[k*DATA_BIT +: DATA_BIT], so the last byte is the control byte.
REQ-018 IDLE + i_rx_done_tick SHALL store byte 0, set o_byte_cnt=1 and move to COLLECT.
REQ-019 COLLECT + i_rx_done_tick SHALL store the byte and increment o_byte_cnt; when the stored byte is byte PACK_NUM-1, the block SHALL move to HOLD.
REQ-020 o_valid SHALL be 1 exactly while in HOLD; it rises the cycle after the last byte's strobe (latency 1 clock).
REQ-021 o_start/o_stop/o_mode/o_channel SHALL decode from the control byte and are valid while o_valid=1; bit 7 is reserved and ignored.
REQ-022 HOLD + i_ready=1 SHALL complete the handshake: o_valid drops the next cycle, o_byte_cnt=0 and the state becomes IDLE.
REQ-023 o_packet SHALL remain stable while o_valid=1.
REQ-024 HOLD + i_rx_done_tick + i_ready=0 SHALL drop the byte and pulse o_overrun_tick for one cycle; the held packet is unchanged.
REQ-025 HOLD + i_rx_done_tick + i_ready=1 in the same cycle SHALL complete the handshake and accept the byte as byte 0 of the next packet (COLLECT, o_byte_cnt=1); no overrun is signalled.
REQ-026 In COLLECT, the timeout counter SHALL clear on every accepted byte and increment on every other cycle.
REQ-027 When the timeout counter reaches TIMEOUT_CLKS-1 without a byte, the block SHALL discard the partial packet, pulse o_timeout_tick, set o_byte_cnt=0 and return to IDLE.
REQ-028 A byte strobe in the same cycle as timeout expiry SHALL win: the byte is accepted, the counter clears and no timeout is raised.
REQ-029 The timeout counter SHALL be held at 0 in IDLE and HOLD; the timeout SHALL never apply in HOLD.
REQ-030 The timeout counter width SHALL be clog2(TIMEOUT_CLKS), and the counter SHALL saturate rather than wrap.

Reset
REQ-031 While rst_n is asserted, the state SHALL be IDLE and o_packet, o_valid, o_start, o_stop, o_mode, o_channel, o_byte_cnt, o_timeout_tick, o_overrun_tick and the timeout counter SHALL all be 0.
REQ-032 Reset asserted mid-packet or in HOLD SHALL discard all partial and held data with no tick pulse; the first strobe after release is byte 0.

Verification
REQ-033 Bytes 55,55,01 with i_ready=1 -> o_valid one cycle, o_packet=0x015555, o_start=1, o_stop=0, o_mode=0, o_channel=0.
REQ-034 Bytes 55,55,1F with i_ready=0 for 100 clk -> o_valid held 100 clk with o_packet stable; a 4th byte AA -> o_overrun_tick=1, o_packet still 0x1F5555.
REQ-035 Byte 55, then no bytes for TIMEOUT_CLKS clk -> o_timeout_tick pulses once, o_byte_cnt=0; then bytes 11,22,3B -> o_packet=0x3B2211, o_channel=7, o_mode=0, o_stop=1, o_start=1.
REQ-036 Byte strobe exactly at the timeout expiry cycle -> no o_timeout_tick, o_byte_cnt increments.
REQ-037 In HOLD, i_ready and a strobe of 77 in the same cycle -> packet released, o_byte_cnt=1, o_packet[7:0]=77 after the next packet completes.
REQ-038 rst_n asserted after 2 bytes -> all outputs 0; bytes 01,02,03 -> o_packet=0x030201.
